// File: rtl/seq_mult_gen.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, LSB first.
// Signed mode gives the multiplier MSB its negative weight by subtracting its term.
module seq_mult_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CTRWIDTH = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 rdy,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CTRWIDTH-1:0] LastCtr = CTRWIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                sgn_q, sgn_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [CTRWIDTH-1:0] ctr_q, ctr_d;
    logic [PW-1:0]       p_q, p_d;
    logic                rdy_q, rdy_d;
    logic                done_q, done_d;

    logic [PW-1:0]       ext_a;
    logic [PW-1:0]       term;
    logic [PW-1:0]       sum;
    logic [WIDTH-1:0]    b_shift;
    logic                bit_set;
    logic                is_last;

    always_comb begin
        ext_a   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        term    = ext_a << ctr_q;
        b_shift = b_q >> ctr_q;
        bit_set = b_shift[0];
        is_last = (ctr_q == LastCtr);
        sum     = acc_q;
        if (bit_set) begin
            // Two's-complement MSB carries weight -2^(WIDTH-1).
            if (sgn_q && is_last) sum = acc_q - term;
            else                  sum = acc_q + term;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        ctr_d   = ctr_q;
        p_d     = p_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = signed_op;
                    acc_d   = '0;
                    ctr_d   = '0;
                    rdy_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d = sum;
                if (is_last) begin
                    p_d     = sum;
                    rdy_d   = 1'b1;
                    done_d  = 1'b1;
                    ctr_d   = '0;
                    state_d = StDone;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            ctr_q   <= '0;
            p_q     <= '0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            ctr_q   <= ctr_d;
            p_q     <= p_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign p    = p_q;
    assign rdy  = rdy_q;
    assign busy = (state_q == StBusy);
    assign done = done_q;

endmodule

// File: tb/tb_seq_mult_gen.sv
// Randomized and directed bench for seq_mult_gen at WIDTH 8, 16 and 5, checked
// against an integer-arithmetic product model.
module tb_seq_mult_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v [3];
    logic        sg_v    [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic [15:0] p8;
    logic [31:0] p16;
    logic [9:0]  p5;
    logic [2:0]  rdy_v, busy_v, done_v;

    int total = 0;
    int bad = 0;
    int wid [3] = '{8, 16, 5};

    always #5 clk = ~clk;

    seq_mult_gen #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start_v[0]), .signed_op(sg_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .p(p8),
        .rdy(rdy_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    seq_mult_gen #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start_v[1]), .signed_op(sg_v[1]),
        .a(a_v[1][15:0]), .b(b_v[1][15:0]), .p(p16),
        .rdy(rdy_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    seq_mult_gen #(.WIDTH(5)) u_dut5 (
        .clk(clk), .reset(reset), .start(start_v[2]), .signed_op(sg_v[2]),
        .a(a_v[2][4:0]), .b(b_v[2][4:0]), .p(p5),
        .rdy(rdy_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get_p(input int k);
        case (k)
            0:       return {48'b0, p8};
            1:       return {32'b0, p16};
            default: return {54'b0, p5};
        endcase
    endfunction

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] model(input int w, input bit sg,
                                          input logic [31:0] av, input logic [31:0] bv);
        longint ia, ib, m;
        logic [63:0] r;
        m  = (longint'(1) << w) - 1;
        ia = longint'({32'b0, av}) & m;
        ib = longint'({32'b0, bv}) & m;
        if (sg && ia[w-1]) ia = ia - (longint'(1) << w);
        if (sg && ib[w-1]) ib = ib - (longint'(1) << w);
        r = 64'(ia * ib);
        return r & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One full operation on instance k with start pulsed for a single cycle.
    task automatic run_op(input int k, input bit sg, input logic [31:0] av,
                          input logic [31:0] bv, input string tag);
        int w = wid[k];
        logic [63:0] exp = model(w, sg, av, bv);
        logic [63:0] p_old;
        int early = 0;
        int moved = 0;
        @(negedge clk);
        sg_v[k] = sg; a_v[k] = av; b_v[k] = bv; start_v[k] = 1'b1;
        p_old = get_p(k);
        @(negedge clk);
        start_v[k] = 1'b0; a_v[k] = $urandom; b_v[k] = $urandom; sg_v[k] = ~sg;
        check({tag, "_busy_start"}, 64'(busy_v[k]), 64'd1);
        check({tag, "_rdy_low"}, 64'(rdy_v[k]), 64'd0);
        for (int i = 1; i < w; i++) begin
            @(negedge clk);
            if (done_v[k] || !busy_v[k]) early++;
            if (get_p(k) !== p_old) moved++;
        end
        check({tag, "_early_done"}, 64'(early), 64'd0);
        check({tag, "_p_hold"}, 64'(moved), 64'd0);
        @(negedge clk);
        check({tag, "_done"}, 64'(done_v[k]), 64'd1);
        check({tag, "_rdy"}, 64'(rdy_v[k]), 64'd1);
        check({tag, "_busy_end"}, 64'(busy_v[k]), 64'd0);
        check({tag, "_p"}, get_p(k), exp);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done_v[k]), 64'd0);
        check({tag, "_p_kept"}, get_p(k), exp);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] av, bv, mx, mn;
        bit sg;
        int first_done, ndone, nbusy, cyc;

        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; sg_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
        end

        // Reset state, with start held high to show it is ignored.
        start_v[0] = 1'b1; a_v[0] = 32'h11; b_v[0] = 32'h22;
        #1;
        check("rst_p", get_p(0), 64'd0);
        check("rst_rdy", 64'(rdy_v[0]), 64'd0);
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ignored", 64'(busy_v[0]), 64'd0);
        @(negedge clk);
        start_v[0] = 1'b0;
        reset = 1'b0;

        run_op(0, 1'b1, 32'h80, 32'h80, "s80x80");
        run_op(0, 1'b0, 32'hFF, 32'hFF, "uFFxFF");
        run_op(0, 1'b1, 32'hFF, 32'hFF, "sFFxFF");
        run_op(0, 1'b1, 32'hFF, 32'h01, "sFFx01");

        // Start during BUSY must be ignored; completion stays on edge 8.
        @(negedge clk);
        sg_v[0] = 1'b0; a_v[0] = 32'd3; b_v[0] = 32'd5; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        first_done = 0; nbusy = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin a_v[0] = 32'd7; b_v[0] = 32'd7; start_v[0] = 1'b1; end
            if (i == 3) start_v[0] = 1'b0;
            @(negedge clk);
            if (done_v[0] && first_done == 0) first_done = i;
            if (i < 8 && busy_v[0]) nbusy++;
        end
        check("ign_done_edge", 64'(first_done), 64'd8);
        check("ign_busy", 64'(nbusy), 64'd7);
        check("ign_p", get_p(0), 64'h000F);

        // Reset mid-run aborts without a done pulse.
        @(negedge clk);
        sg_v[0] = 1'b0; a_v[0] = 32'h55; b_v[0] = 32'h33; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_p", get_p(0), 64'd0);
        check("abort_rdy", 64'(rdy_v[0]), 64'd0);
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run_op(0, 1'b0, 32'd2, 32'd3, "after_abort");

        // Back-to-back: start held high, new operands presented at each DONE.
        @(negedge clk);
        sg = 1'($urandom); av = $urandom; bv = $urandom;
        sg_v[0] = sg; a_v[0] = av; b_v[0] = bv; start_v[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp = model(8, sg, av, bv);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done_v[0] && cyc < 20);
            check("b2b_period", 64'(cyc), 64'd9);
            check("b2b_p", get_p(0), exp);
            sg = 1'($urandom); av = $urandom; bv = $urandom;
            sg_v[0] = sg; a_v[0] = av; b_v[0] = bv;
        end
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);

        // Random and extreme operands on all three widths.
        for (int k = 0; k < 3; k++) begin
            mx = (32'd1 << wid[k]) - 32'd1;
            mn = 32'd1 << (wid[k] - 1);
            for (int n = 0; n < 14; n++) begin
                sg = 1'($urandom);
                av = $urandom & mx;
                bv = $urandom & mx;
                case (n)
                    0: begin av = 0;  bv = mx; end
                    1: begin av = mx; bv = mx; end
                    2: begin av = mn; bv = mn; end
                    3: begin av = mn; bv = mx; end
                    4: begin av = mn - 1; bv = mn; end
                    default: ;
                endcase
                run_op(k, sg, av, bv, $sformatf("w%0d_r%0d", wid[k], n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
